// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS core: FSM states, opcode/funct
// constants and the 4-bit ALU control encoding.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [3:0] funct_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_mips_core_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write
// port, register 0 hardwired to zero.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata
);

  logic [DW-1:0] r_regs [NREG];

  // NOTE: the array is reset because every register must read zero after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mc_mips_core.sv
// Multicycle MIPS core with a single req/ack memory port and internal control FSM.
// Define MC_JUMP_EN to decode opcode 0x02 (j); otherwise it halts as illegal.
module mc_mips_core
  import mc_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            NREG     = 32,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] pc,
  output logic          halted,
  output logic          illegal
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_pc, r_a, r_b, r_alu_out, r_mdr, r_mem_addr, r_mem_wdata;
  logic [31:0]   r_ir;
  logic          r_mem_req, r_mem_we, r_illegal;

  logic [DW-1:0] w_pc_nxt, w_launch_addr, w_imm_sext, w_br_off, w_alu_b, w_alu_res;
  logic [DW-1:0] w_rf_a, w_rf_b, w_rf_wdata;
  logic [AW-1:0] w_rf_waddr;
  logic [5:0]    w_opcode, w_funct;
  logic [3:0]    w_alu_op;
  logic          w_xfer, w_launch, w_launch_we, w_illegal_nxt, w_rf_we, w_unused;

  assign w_opcode   = r_ir[31:26];
  assign w_funct    = r_ir[5:0];
  assign w_imm_sext = {{(DW-16){r_ir[15]}}, r_ir[15:0]};
  assign w_br_off   = {{(DW-18){r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_xfer     = r_mem_req && mem_ack;
  assign w_unused   = ^r_ir[10:6];

  assign w_rf_we    = (r_state == WB);
  assign w_rf_waddr = (w_opcode == OP_RTYPE) ? r_ir[11 +: AW] : r_ir[16 +: AW];
  assign w_rf_wdata = (w_opcode == OP_LW) ? r_mdr : r_alu_out;

  mc_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (r_ir[21 +: AW]),
    .i_raddr_b (r_ir[16 +: AW]),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata)
  );

  assign w_alu_b  = (w_opcode == OP_RTYPE) ? r_b : w_imm_sext;
  assign w_alu_op = (w_opcode == OP_RTYPE) ? funct_to_alu(w_funct) : ALU_ADD;

  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_AND: w_alu_res = r_a & w_alu_b;
      ALU_OR:  w_alu_res = r_a | w_alu_b;
      ALU_SUB: w_alu_res = r_a - w_alu_b;
      ALU_SLT: w_alu_res = {{(DW-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_res = r_a + w_alu_b;
    endcase
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_illegal_nxt = r_illegal;
    case (r_state)
      FETCH: if (w_xfer) begin
        w_state_nxt = DECODE;
        w_pc_nxt    = r_pc + DW'(4);
      end
      DECODE: case (w_opcode)
        OP_RTYPE: if (funct_legal(w_funct)) w_state_nxt = EXEC;
                  else begin w_state_nxt = HALT; w_illegal_nxt = 1'b1; end
        OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_state_nxt = EXEC;
        OP_HALT: w_state_nxt = HALT;
`ifdef MC_JUMP_EN
        OP_J: begin
          w_state_nxt = FETCH;
          w_pc_nxt    = {r_pc[DW-1:28], r_ir[25:0], 2'b00};
        end
`endif
        default: begin w_state_nxt = HALT; w_illegal_nxt = 1'b1; end
      endcase
      EXEC: case (w_opcode)
        OP_BEQ: begin
          w_state_nxt = FETCH;
          if (r_a == r_b) w_pc_nxt = r_pc + w_br_off;
        end
        OP_LW, OP_SW: w_state_nxt = MEM;
        default:      w_state_nxt = WB;
      endcase
      MEM:     if (w_xfer) w_state_nxt = (w_opcode == OP_LW) ? WB : FETCH;
      WB:      w_state_nxt = FETCH;
      default: w_state_nxt = HALT;
    endcase

    // A transfer is launched on entry to FETCH/MEM so the request is already
    // registered in that state's first cycle; reset leaves FETCH without one.
    w_launch      = 1'b0;
    w_launch_we   = 1'b0;
    w_launch_addr = w_pc_nxt;
    if ((w_state_nxt == FETCH) && ((r_state != FETCH) || !r_mem_req)) begin
      w_launch = 1'b1;
    end else if ((w_state_nxt == MEM) && (r_state != MEM)) begin
      w_launch      = 1'b1;
      w_launch_we   = (w_opcode == OP_SW);
      w_launch_addr = w_alu_res;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu_out   <= '0;
      r_mdr       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_illegal <= w_illegal_nxt;
      if (w_launch) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_launch_we;
        r_mem_addr  <= w_launch_addr;
        r_mem_wdata <= r_b;
      end else if (w_xfer) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
      case (r_state)
        FETCH:  if (w_xfer) r_ir <= mem_rdata[31:0];
        DECODE: begin r_a <= w_rf_a; r_b <= w_rf_b; end
        EXEC:   r_alu_out <= w_alu_res;
        MEM:    if (w_xfer && (w_opcode == OP_LW)) r_mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign pc        = r_pc;
  assign halted    = (r_state == HALT);
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_mc_mips_core.sv
// Self-checking bench for mc_mips_core: an instruction-level reference model
// predicts the memory transfer sequence, final memory, PC, flags and cycle count.
module tb_mc_mips_core;
  import mc_pkg::*;

  localparam int MW = 512;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ack, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  mc_mips_core #(.DW(32), .NREG(32), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Memory: reloaded from prog while rst is high; ack after wait_cfg wait cycles.
  logic [31:0] prog [MW];
  logic [31:0] mem  [MW];
  int          wait_cfg = 0;
  int          wait_cnt = 0;

  assign mem_ack   = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[10:2]];

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (rst) begin
      for (int i = 0; i < MW; i++) mem[i] <= prog[i];
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[10:2]] <= mem_wdata;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  xfer_t       obs_q[$];
  xfer_t       exp_q[$];
  logic [31:0] exp_mem [MW];
  logic [31:0] exp_pc;
  logic        exp_illegal;
  int          exp_cycles;
  logic        prev_valid, prev_req, prev_ack, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'h0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < MW; i++) prog[i] = 32'h0;
  endtask

  // Instruction-level reference: executes the program and sums per-instruction
  // latencies (each memory transfer costs 1 + w cycles).
  task automatic model_run(input int w);
    logic [31:0] r [32];
    logic [31:0] p, ir, a, b, imm, res, ad;
    bit          done;
    int          steps;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    for (int i = 0; i < MW; i++) exp_mem[i] = prog[i];
    exp_q.delete();
    p = 32'h0; exp_cycles = 0; exp_illegal = 1'b0; done = 0; steps = 0;
    while (!done && steps < 2000) begin
      steps++;
      exp_q.push_back('{1'b0, p, 32'h0});
      ir = exp_mem[p[10:2]];
      p  = p + 32'd4;
      exp_cycles += 2 + w;
      a   = r[ir[25:21]];
      b   = r[ir[20:16]];
      imm = {{16{ir[15]}}, ir[15:0]};
      ad  = a + imm;
      case (ir[31:26])
        6'h00: begin
          case (ir[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin exp_illegal = 1'b1; done = 1; res = 32'h0; end
          endcase
          if (!done) begin
            if (ir[15:11] != 5'd0) r[ir[15:11]] = res;
            exp_cycles += 2;
          end
        end
        6'h08: begin
          if (ir[20:16] != 5'd0) r[ir[20:16]] = ad;
          exp_cycles += 2;
        end
        6'h23: begin
          exp_q.push_back('{1'b0, ad, 32'h0});
          if (ir[20:16] != 5'd0) r[ir[20:16]] = exp_mem[ad[10:2]];
          exp_cycles += 3 + w;
        end
        6'h2B: begin
          exp_q.push_back('{1'b1, ad, b});
          exp_mem[ad[10:2]] = b;
          exp_cycles += 2 + w;
        end
        6'h04: begin
          if (a == b) p = p + (imm << 2);
          exp_cycles += 1;
        end
        6'h3F: done = 1;
`ifdef MC_JUMP_EN
        6'h02: p = {p[31:28], ir[25:0], 2'b00};
`endif
        default: begin exp_illegal = 1'b1; done = 1; end
      endcase
    end
    exp_pc = p;
  endtask

  // One clock: sample at the falling edge, check request stability, log transfers.
  task automatic step();
    @(negedge clk);
    if (prev_valid) begin
      if (prev_req && !prev_ack) begin
        check("hold_req", {31'b0, mem_req}, 32'd1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_we", {31'b0, mem_we}, {31'b0, prev_we});
        if (prev_we) check("hold_wdata", mem_wdata, prev_wdata);
      end
      if (prev_req && prev_ack && !prev_we) check("req_drop_after_read", {31'b0, mem_req}, 32'd0);
    end
    if (mem_req && mem_ack) obs_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
    prev_valid = 1'b1;
    prev_req   = mem_req;
    prev_ack   = mem_ack;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  endtask

  task automatic start_run(input int w);
    wait_cfg = w;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs_q.delete();
    prev_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_prog(input string name, input int w, output int cyc);
    int guard, bad, nq, sawreq;
    model_run(w);
    start_run(w);
    guard = 0;
    do begin step(); guard++; end while (!mem_req && guard < 10);
    cyc = 0;
    while (!halted && cyc < 5000) begin step(); cyc++; end
    check({name, ":halted"}, {31'b0, halted}, 32'd1);
    check({name, ":cycles"}, cyc, exp_cycles);
    check({name, ":illegal"}, {31'b0, illegal}, {31'b0, exp_illegal});
    check({name, ":pc"}, pc, exp_pc);
    sawreq = 0;
    repeat (8) begin step(); if (mem_req) sawreq++; end
    check({name, ":no_req_in_halt"}, sawreq, 0);
    check({name, ":xfer_count"}, obs_q.size(), exp_q.size());
    nq = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    bad = 0;
    for (int i = 0; i < nq; i++) if (obs_q[i] !== exp_q[i]) bad++;
    check({name, ":xfer_seq"}, bad, 0);
    bad = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({name, ":mem_image"}, bad, 0);
  endtask

  function automatic logic [31:0] obs_addr(input int idx);
    return (obs_q.size() > idx) ? obs_q[idx].addr : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int          cyc, guard, L, k, rs, rt, rd, off;
    logic [5:0]  fn_tab [5];
    logic [15:0] imm;
    fn_tab = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    clear_prog();

    repeat (2) @(negedge clk);
    check("reset:mem_req", {31'b0, mem_req}, 32'd0);
    check("reset:mem_we", {31'b0, mem_we}, 32'd0);
    check("reset:halted", {31'b0, halted}, 32'd0);
    check("reset:illegal", {31'b0, illegal}, 32'd0);
    check("reset:pc", pc, 32'h0);

    // Basic arithmetic, zero-wait: halt 14 cycles after the first request.
    clear_prog();
    prog[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    prog[1] = enc_i(OP_ADDI, 0, 2, 16'd7);
    prog[2] = enc_r(1, 2, 3, FN_ADD);
    prog[3] = {OP_HALT, 26'h0};
    run_prog("arith", 0, cyc);
    check("arith:cycles_14", cyc, 14);

    // Store/load with three wait cycles on every request.
    prog[3] = enc_i(OP_SW, 0, 3, 16'h0040);
    prog[4] = enc_i(OP_LW, 0, 4, 16'h0040);
    prog[5] = enc_i(OP_SW, 0, 4, 16'h0044);
    prog[6] = {OP_HALT, 26'h0};
    run_prog("swlw", 3, cyc);
    check("swlw:mem40", mem[32'h40 >> 2], 32'd12);
    check("swlw:r4", mem[32'h44 >> 2], 32'd12);

    // Branch at 0x10, taken and not taken.
    clear_prog();
    prog[0] = enc_i(OP_ADDI, 0, 1, 16'd3);
    prog[1] = enc_i(OP_ADDI, 0, 2, 16'd4);
    prog[2] = enc_r(0, 0, 0, FN_ADD);
    prog[3] = enc_r(0, 0, 0, FN_ADD);
    prog[4] = enc_i(OP_BEQ, 1, 1, 16'd2);
    prog[5] = {OP_HALT, 26'h0};
    prog[6] = {OP_HALT, 26'h0};
    prog[7] = {OP_HALT, 26'h0};
    run_prog("beq_taken", 0, cyc);
    check("beq_taken:next_fetch", obs_addr(5), 32'h1C);
    prog[4] = enc_i(OP_BEQ, 1, 2, 16'd2);
    run_prog("beq_not", 1, cyc);
    check("beq_not:next_fetch", obs_addr(5), 32'h14);

    // Negative immediate, signed compare, R0 write discard.
    clear_prog();
    prog[0] = enc_i(OP_ADDI, 0, 5, 16'hFFFF);
    prog[1] = enc_r(5, 0, 6, FN_SLT);
    prog[2] = enc_i(OP_ADDI, 0, 0, 16'd9);
    prog[3] = enc_i(OP_SW, 0, 5, 16'h0050);
    prog[4] = enc_i(OP_SW, 0, 6, 16'h0054);
    prog[5] = enc_i(OP_SW, 0, 0, 16'h0058);
    prog[6] = {OP_HALT, 26'h0};
    prog[32'h58 >> 2] = 32'hAAAA_5555;
    run_prog("slt", 0, cyc);
    check("slt:r5", mem[32'h50 >> 2], 32'hFFFF_FFFF);
    check("slt:r6", mem[32'h54 >> 2], 32'd1);
    check("slt:r0", mem[32'h58 >> 2], 32'd0);

    // Unknown opcode, then opcode 0x02 (jump or illegal depending on build).
    clear_prog();
    prog[0] = {6'h3E, 26'h0};
    run_prog("op3e", 0, cyc);
    check("op3e:illegal", {31'b0, illegal}, 32'd1);
    prog[0] = {OP_J, 26'h100};
    prog[32'h400 >> 2] = {OP_HALT, 26'h0};
    run_prog("op02", 0, cyc);
`ifdef MC_JUMP_EN
    check("op02:jump_target", obs_addr(1), 32'h400);
    check("op02:illegal", {31'b0, illegal}, 32'd0);
`else
    check("op02:illegal", {31'b0, illegal}, 32'd1);
`endif

    // Reset asserted while a load request is waiting for ack.
    clear_prog();
    prog[0] = enc_i(OP_LW, 0, 1, 16'h0040);
    prog[1] = {OP_HALT, 26'h0};
    start_run(5);
    guard = 0;
    do begin step(); guard++; end while (!(mem_req && mem_addr == 32'h40) && guard < 60);
    check("rst_mem:found_req", {31'b0, mem_req && mem_addr == 32'h40}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mem:req_low", {31'b0, mem_req}, 32'd0);
    check("rst_mem:pc", pc, 32'h0);
    @(negedge clk);
    prev_valid = 1'b0;
    rst = 1'b0;
    guard = 0;
    do begin step(); guard++; end while (!mem_req && guard < 10);
    check("rst_mem:first_req", {31'b0, mem_req}, 32'd1);
    check("rst_mem:first_addr", mem_addr, 32'h0);
    check("rst_mem:first_we", {31'b0, mem_we}, 32'd0);

    // Random legal programs ending in a register dump.
    for (int t = 0; t < 6; t++) begin
      clear_prog();
      for (int i = 0; i < 16; i++) prog[(32'h200 >> 2) + i] = $urandom;
      L = 14;
      for (int i = 0; i < L; i++) begin
        k  = $urandom_range(0, 5);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(1, 7);
        rd = $urandom_range(0, 7);
        imm = 16'(32'h200 + 4 * $urandom_range(0, 15));
        case (k)
          0:       prog[i] = enc_i(OP_ADDI, rs, rt, 16'($urandom));
          1, 2:    prog[i] = enc_r(rs, rt, rd, fn_tab[$urandom_range(0, 4)]);
          3:       prog[i] = enc_i(OP_SW, 0, rt, imm);
          4:       prog[i] = enc_i(OP_LW, 0, rt, imm);
          default: begin
            off = $urandom_range(0, (L - 1 - i) < 2 ? (L - 1 - i) : 2);
            prog[i] = enc_i(OP_BEQ, rs, rt, 16'(off));
          end
        endcase
      end
      for (int r = 1; r < 8; r++) prog[L + r - 1] = enc_i(OP_SW, 0, r, 16'(32'h300 + 4 * r));
      prog[L + 7] = {OP_HALT, 26'h0};
      run_prog($sformatf("rand%0d", t), $urandom_range(0, 2), cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_mips_core.md
Name: mc_mips_core

Overview:
- Multicycle successor to the single-cycle MIPS datapath.
- One unified memory port with a req/ack handshake, so fetches and data accesses can have wait states.
- An internal control FSM replaces the external control lines. Data width and register-file depth are parametrised.
- Sits between the testbench/top level and a shared instruction+data SRAM wrapper.

Parameters:
- DW, 32: datapath, register and PC width. Must be >= 32. The instruction is always mem_rdata[31:0].
- NREG, 32: number of registers. Power of 2, <= 32. Register index = low log2(NREG) bits of rs/rt/rd.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  DW  byte address; word aligned
- mem_wdata  out  DW  store data; valid while mem_req && mem_we
- mem_rdata  in  DW  read data; sampled in the cycle mem_req && mem_ack
- mem_ack  in  1  transfer completes in any cycle where mem_req && mem_ack; may be combinational
- pc  out  DW  current PC
- halted  out  1  core stopped, in HALT
- illegal  out  1  halted on an unknown opcode

Behaviour:
- Reset (async):
  - PC = RESET_PC; state = FETCH.
  - IR, A, B, ALUOut, MDR = 0; all registers = 0.
  - mem_req = 0, mem_we = 0, halted = 0, illegal = 0.
  - Asserting rst mid-transaction drops mem_req immediately; the memory side must tolerate this.
- Outputs: mem_req, mem_we, mem_addr and mem_wdata are registered. They stay stable from req rise until the ack cycle, and req drops in the cycle after ack.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - req = 1, we = 0, addr = PC.
  - On ack: IR <= rdata[31:0]; PC <= PC+4; go to DECODE.
- DECODE:
  - A <= R[rs], B <= R[rt].
  - Opcode decode: 0x00 R-type, 0x23 lw, 0x2B sw, 0x04 beq, 0x08 addi, 0x3F halt.
  - Any other opcode, or a funct other than 0x20/0x22/0x24/0x25/0x2A: go to HALT with illegal = 1.
  - 0x3F: go to HALT with illegal = 0.
- EXEC:
  - ALUOut <= A op (B or sext(imm16) to DW).
  - Funct mapping: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. slt is signed and gives 1 or 0.
  - Arithmetic wraps mod 2^DW; no overflow trap.
  - beq: if A == B, PC <= PC + (sext(imm) << 2), using the already-incremented PC; then go to FETCH.
  - lw and sw go to MEM. R-type and addi go to WB.
- MEM:
  - req = 1, addr = ALUOut, we = (sw), wdata = B.
  - On ack: lw does MDR <= rdata and goes to WB; sw goes to FETCH.
- WB:
  - R-type: R[rd] <= ALUOut. addi: R[rt] <= ALUOut. lw: R[rt] <= MDR.
  - Writes to register 0 are discarded; R0 always reads 0.
  - Then go to FETCH.
- HALT:
  - Terminal state; halted = 1; no requests issued.
  - Exit only via rst.
- Latency with a zero-wait (combinational) ack: beq 3, sw 4, R-type/addi 4, lw 5 cycles. Each wait cycle of ack adds 1.
- Register read-after-write: a WB write is visible to the next instruction's DECODE, so no hazards exist.
- Unaligned addresses: low 2 bits are passed through unchanged; alignment is the memory's concern.

Optional Feature:
- Macro: MC_JUMP_EN.
- When defined:
  - Opcode 0x02 (j) decodes in DECODE as PC <= {PC[DW-1:28], target26, 2'b00}, then goes to FETCH. Latency is 2 cycles plus fetch wait.
- When undefined: 0x02 is illegal (HALT, illegal = 1).

Decomposition:
- Shared package mc_pkg:
  - State enum (FETCH..HALT).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_HALT, OP_J.
  - Funct constants.
  - ALU op codes, on the 4-bit ALUcontrol encoding used by the existing alu.
- Natural sub-module: mc_regfile, NREG x DW with 2 asynchronous read ports, 1 synchronous write port and hardwired R0.
- ALU and sign-extend are implemented in the top level.

Test Plan:
- Zero-wait memory; program is addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt.
  - Expect R3 = 12, halted = 1, illegal = 0.
  - Halt reached at cycle 4+4+4+2 = 14 after reset release.
- Store and load: sw $3,0x40($0) then lw $4,0x40($0), with ack delayed 3 cycles on every request.
  - Expect mem[0x40] = 12 and R4 = 12.
  - mem_addr and mem_wdata must be stable for all wait cycles; req must drop the cycle after ack.
- Branch: beq $1,$1,+2 at PC 0x10.
  - Next fetch address must be 0x1C.
  - With unequal operands, the next fetch is 0x14.
- Negative and compare: addi $5,$0,-1 then slt $6,$5,$0.
  - Expect R5 = 0xFFFFFFFF and R6 = 1.
  - addi $0,$0,9 must leave R0 = 0.
- Illegal opcode 0x3E: expect halted = 1, illegal = 1, and no further mem_req.
  - With MC_JUMP_EN off, 0x02 gives the same result; with it on, j 0x100 fetches next from 0x400.
- Assert rst during a MEM request (before ack): mem_req falls asynchronously, pc = RESET_PC, and the first post-reset request is a fetch at RESET_PC.
